alu_issue_queue: RTL

Upstream issue stage for the 4-bit combinational ALU. It accepts operation requests over a valid/ready handshake and buffers them in a small FIFO. It drives the ALU operand and select inputs from a registered issue stage, then captures the ALU result and carry into a registered output stage with its own valid/ready handshake. An optional accumulator mode replaces operand A with the previous result, with a hardware interlock.

---
 rtl/alu_issue_queue.sv | 130 +++++++++++++
 1 files changed

// File: rtl/alu_issue_queue.sv
// Issue queue in front of the 4-bit ALU: request FIFO, registered issue stage driving the ALU,
// registered result stage with valid/ready, and an interlocked accumulator operand mode.
module alu_issue_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_op,
    input  logic [3:0]               in_a,
    input  logic [3:0]               in_b,
    input  logic                     in_acc,
    output logic [3:0]               alu_a,
    output logic [3:0]               alu_b,
    output logic [2:0]               alu_sel,
    input  logic [3:0]               alu_result,
    input  logic                     alu_carry,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [3:0]               out_result,
    output logic                     out_carry,
    output logic [3:0]               acc_value,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef struct packed {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic       acc;
    } req_t;

    req_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    req_t          head;
    req_t          wr_req;
    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic          s1_valid;
    logic          s2_free;
    logic          s1_adv;
    logic          s1_load;
    logic          carry_defined;

    assign head       = mem[rd_ptr];
    assign wr_req     = '{op: in_op, a: in_a, b: in_b, acc: in_acc};
    assign fifo_empty = (fifo_count == '0);
    assign in_ready   = (fifo_count < FULL_CNT);
    assign push       = in_valid & in_ready;

    assign s2_free = !out_valid | out_ready;
    assign s1_adv  = s1_valid & s2_free;

    // An accumulator op waits for an empty s1 so acc_value already holds every earlier result.
    assign s1_load = !fifo_empty && (!s1_valid || s1_adv) && (!head.acc || !s1_valid);
    assign pop     = s1_load;

    // alu_sel still holds the op of the entry sitting in s1.
    assign carry_defined = (alu_sel == 3'b000) || (alu_sel == 3'b001);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_req;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_sel  <= '0;
        end else begin
            if (s1_load) begin
                s1_valid <= 1'b1;
                alu_a    <= head.acc ? acc_value : head.a;
                alu_b    <= head.b;
                alu_sel  <= head.op;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_carry  <= 1'b0;
            acc_value  <= '0;
        end else begin
            if (s1_adv) begin
                out_valid  <= 1'b1;
                out_result <= alu_result;
                out_carry  <= carry_defined ? alu_carry : 1'b0;
                acc_value  <= alu_result;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
